auto_navigator: RTL and testbench

Autonomous-driving decision block that initiates the timed turns executed by the auto_turning block. It debounces the three obstacle detectors and applies a left-hand wall-following rule. It asserts one of trigger_turn_left/right/back, then tracks the turning block's is_turning output as the acknowledge/complete handshake. Between turns it drives move_forward to the motion controller. It runs on the 500 Hz system clock.

---
 rtl/auto_navigator.sv | 182 ++++++++++++++++++
 tb/tb_auto_navigator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_navigator.sv
// Wall-following navigator: debounces three obstacle detectors, requests timed
// turns from the turning block and drives forward motion between turns.
module auto_navigator #(
    parameter int unsigned DEBOUNCE    = 5,
    parameter int unsigned EXIT_HOLD   = 250,
    parameter int unsigned ACK_TIMEOUT = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       detector_front,
    input  logic       detector_left,
    input  logic       detector_right,
    input  logic       is_turning,
    output logic       trigger_turn_left,
    output logic       trigger_turn_right,
    output logic       trigger_turn_back,
    output logic       move_forward,
    output logic [2:0] nav_state,
    output logic       ack_fault
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(EXIT_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CRUISE  = 3'd1,
        S_REQ     = 3'd2,
        S_TURNING = 3'd3,
        S_EXIT    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_BACK  = 2'd2
    } dir_t;

    // Detector bit order: 0 = front, 1 = left, 2 = right
    logic [2:0]       raw;
    logic [2:0]       db;
    logic [CNT_W-1:0] db_cnt [3];

    state_t           state;
    state_t           state_nxt;
    dir_t             dir;
    dir_t             dir_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       trig_nxt;
    logic             mf_nxt;
    logic             fault_nxt;

    assign raw       = {detector_right, detector_left, detector_front};
    assign nav_state = state;

    // Debounce: accept a new value after DEBOUNCE consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            db <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (raw[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    db[i]     <= raw[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            dir                <= DIR_LEFT;
            cnt                <= '0;
            trigger_turn_left  <= 1'b0;
            trigger_turn_right <= 1'b0;
            trigger_turn_back  <= 1'b0;
            move_forward       <= 1'b0;
            ack_fault          <= 1'b0;
        end else begin
            state              <= state_nxt;
            dir                <= dir_nxt;
            cnt                <= cnt_nxt;
            trigger_turn_left  <= trig_nxt[2];
            trigger_turn_right <= trig_nxt[1];
            trigger_turn_back  <= trig_nxt[0];
            move_forward       <= mf_nxt;
            ack_fault          <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        trig_nxt  = 3'b000;
        mf_nxt    = 1'b0;
        fault_nxt = ack_fault;

        // Losing enable outranks every other event, including an ack
        if (!enable) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_CRUISE;
                    cnt_nxt   = '0;
                end
                S_CRUISE: begin
                    cnt_nxt = '0;
                    if (!db[1]) begin
                        state_nxt = S_REQ;
                        dir_nxt   = DIR_LEFT;
                    end else if (!db[0]) begin
                        mf_nxt = 1'b1;
                    end else if (!db[2]) begin
                        state_nxt = S_REQ;
                        dir_nxt   = DIR_RIGHT;
                    end else begin
                        state_nxt = S_REQ;
                        dir_nxt   = DIR_BACK;
                    end
                end
                S_REQ: begin
                    if (is_turning) begin
                        state_nxt = S_TURNING;
                        cnt_nxt   = '0;
                    end else if (cnt >= ACK_LAST) begin
                        state_nxt = S_CRUISE;
                        fault_nxt = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                S_TURNING: begin
                    if (!is_turning) begin
                        state_nxt = S_EXIT;
                        cnt_nxt   = HOLD_LOAD;
                        mf_nxt    = 1'b1;
                    end
                end
                S_EXIT: begin
                    if (cnt <= CNT_ONE) begin
                        state_nxt = S_CRUISE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                        mf_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // A trigger is high exactly while a request is outstanding
        if (state_nxt == S_REQ) begin
            case (dir_nxt)
                DIR_LEFT:  trig_nxt = 3'b100;
                DIR_RIGHT: trig_nxt = 3'b010;
                default:   trig_nxt = 3'b001;
            endcase
        end
    end

endmodule

// File: tb/tb_auto_navigator.sv
// Directed bench for auto_navigator: a behavioural model checked every cycle
// plus hand-computed latency and pulse-length expectations.
module tb_auto_navigator;

    localparam int DEB  = 5;
    localparam int HOLD = 250;
    localparam int ACKT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       df;
    logic       dl;
    logic       dr;
    logic       is_turning;
    logic       tl;
    logic       tr;
    logic       tb;
    logic       mf;
    logic [2:0] nav_state;
    logic       ack_fault;

    int total = 0;
    int bad   = 0;
    int n;

    auto_navigator #(
        .DEBOUNCE(DEB), .EXIT_HOLD(HOLD), .ACK_TIMEOUT(ACKT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .detector_front(df), .detector_left(dl), .detector_right(dr),
        .is_turning(is_turning),
        .trigger_turn_left(tl), .trigger_turn_right(tr), .trigger_turn_back(tb),
        .move_forward(mf), .nav_state(nav_state), .ack_fault(ack_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: accepted detector values and the navigation mode
    bit acc [3];
    bit win [3][DEB];
    int seen [3];
    int m_mode;
    int m_dir;
    int req_age;
    int hold_left;
    bit e_tl, e_tr, e_tb, e_mf, e_fault;
    bit model_ready = 1'b0;

    always @(posedge clk) begin : model
        bit smp [3];
        bit all_diff;
        smp[0] = df; smp[1] = dl; smp[2] = dr;
        model_ready = 1'b1;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                acc[i]  = 1'b1;
                seen[i] = 0;
            end
            m_mode = 0; m_dir = 0; req_age = 0; hold_left = 0;
            e_tl = 0; e_tr = 0; e_tb = 0; e_mf = 0; e_fault = 0;
        end else begin
            e_tl = 0; e_tr = 0; e_tb = 0; e_mf = 0;
            if (!enable) begin
                m_mode = 0;
            end else begin
                case (m_mode)
                    0: m_mode = 1;
                    1: begin
                        if (!acc[1]) begin m_mode = 2; m_dir = 0; req_age = 0; end
                        else if (!acc[0]) e_mf = 1;
                        else if (!acc[2]) begin m_mode = 2; m_dir = 1; req_age = 0; end
                        else begin m_mode = 2; m_dir = 2; req_age = 0; end
                    end
                    2: begin
                        if (is_turning) m_mode = 3;
                        else begin
                            req_age++;
                            if (req_age >= ACKT) begin m_mode = 1; e_fault = 1; end
                        end
                    end
                    3: if (!is_turning) begin m_mode = 4; hold_left = HOLD; e_mf = 1; end
                    4: begin
                        hold_left--;
                        if (hold_left == 0) m_mode = 1;
                        else e_mf = 1;
                    end
                    default: m_mode = 0;
                endcase
            end
            if (m_mode == 2) begin
                e_tl = (m_dir == 0); e_tr = (m_dir == 1); e_tb = (m_dir == 2);
            end
            // Accept a value once the last DEB samples all disagree with it
            for (int i = 0; i < 3; i++) begin
                for (int k = DEB - 1; k > 0; k--) win[i][k] = win[i][k-1];
                win[i][0] = smp[i];
                seen[i]++;
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++) if (win[i][k] == acc[i]) all_diff = 1'b0;
                if (seen[i] >= DEB && all_diff) acc[i] = smp[i];
            end
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            chk("nav_state", int'(nav_state), m_mode);
            chk("trig_left", int'(tl), int'(e_tl));
            chk("trig_right", int'(tr), int'(e_tr));
            chk("trig_back", int'(tb), int'(e_tb));
            chk("move_forward", int'(mf), int'(e_mf));
            chk("ack_fault", int'(ack_fault), int'(e_fault));
        end
    end

    function automatic bit cond(input int sel);
        case (sel)
            0:       return mf;
            1:       return tl | tr | tb;
            2:       return nav_state == 3'd1;
            3:       return nav_state == 3'd3;
            default: return nav_state == 3'd4;
        endcase
    endfunction

    task automatic wait_until(input string name, input int sel, input int bound, output int cyc);
        cyc = 0;
        while (!cond(sel) && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!cond(sel)) begin
            bad++;
            $display("FAIL %s: condition not reached within %0d cycles", name, bound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; enable = 0; df = 0; dl = 0; dr = 0; is_turning = 0;
        repeat (3) @(negedge clk);
        chk("reset_nav", int'(nav_state), 0);
        chk("reset_mf", int'(mf), 0);
        chk("reset_trig", int'({tl, tr, tb}), 0);
        chk("reset_fault", int'(ack_fault), 0);

        // Let detectors settle while idle, then cruise with front open
        rst = 0; df = 0; dl = 1; dr = 1;
        repeat (DEB + 2) @(negedge clk);
        chk("idle_nav", int'(nav_state), 0);
        enable = 1;
        wait_until("cruise_mf", 0, DEB + 2, n);
        chk("cruise_latency", n, 2);
        chk("cruise_nav", int'(nav_state), 1);
        chk("cruise_trig", int'({tl, tr, tb}), 0);

        // Left opening -> left turn request, ack two cycles later
        dl = 0;
        wait_until("left_trig", 1, 20, n);
        chk("left_latency", n, DEB + 1);
        chk("left_only", int'({tl, tr, tb}), 3'b100);
        @(negedge clk);
        chk("left_held", int'(tl), 1);
        is_turning = 1; dl = 1;
        @(negedge clk);
        chk("left_ack_clears", int'({tl, tr, tb}), 0);
        chk("left_turning", int'(nav_state), 3);
        repeat (374) @(negedge clk);
        is_turning = 0;
        wait_until("exit_start", 0, 5, n);
        chk("exit_nav", int'(nav_state), 4);
        n = 0;
        while (mf && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("exit_len", n, HOLD);
        chk("exit_to_cruise", int'(nav_state), 1);
        wait_until("cruise_again", 0, 5, n);
        chk("cruise_again_latency", n, 1);

        // All walled -> U-turn request
        df = 1;
        wait_until("back_trig", 1, 20, n);
        chk("back_only", int'({tl, tr, tb}), 3'b001);
        is_turning = 1;
        @(negedge clk);
        chk("back_turning", int'(nav_state), 3);
        is_turning = 0; dr = 0;
        wait_until("back_exit", 4, 5, n);
        wait_until("back_cruise", 2, 300, n);

        // Right opening -> right request, never acknowledged
        wait_until("right_trig", 1, 10, n);
        chk("right_only", int'({tl, tr, tb}), 3'b010);
        chk("fault_before", int'(ack_fault), 0);
        n = 0;
        while (tr && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_len", n, ACKT);
        chk("timeout_fault", int'(ack_fault), 1);
        chk("timeout_nav", int'(nav_state), 1);

        // Acknowledge the retried request and return to forward cruise
        is_turning = 1; df = 0; dr = 1;
        wait_until("retry_turn", 3, 10, n);
        repeat (10) @(negedge clk);
        is_turning = 0;
        wait_until("retry_cruise", 2, 300, n);
        wait_until("retry_mf", 0, 5, n);
        chk("fault_sticky", int'(ack_fault), 1);

        // Short left glitch is filtered out
        dl = 0;
        repeat (3) @(negedge clk);
        dl = 1;
        repeat (12) @(negedge clk);
        chk("glitch_no_trig", int'({tl, tr, tb}), 0);
        chk("glitch_mf", int'(mf), 1);
        chk("glitch_nav", int'(nav_state), 1);

        // Enable fall coinciding with ack -> idle
        dl = 0;
        wait_until("left2_trig", 1, 20, n);
        enable = 0; is_turning = 1;
        @(negedge clk);
        chk("en_wins_nav", int'(nav_state), 0);
        chk("en_wins_out", int'({tl, tr, tb, mf}), 0);

        // Enable drop while turning
        enable = 1;
        wait_until("turn2", 3, 20, n);
        chk("turn2_latency", n, 3);
        enable = 0;
        @(negedge clk);
        chk("drop_nav", int'(nav_state), 0);
        chk("drop_out", int'({tl, tr, tb, mf}), 0);

        // Reset while turning
        enable = 1;
        wait_until("turn3", 3, 20, n);
        rst = 1;
        @(negedge clk);
        chk("rst_turn_nav", int'(nav_state), 0);
        chk("rst_turn_out", int'({tl, tr, tb, mf}), 0);
        chk("rst_turn_fault", int'(ack_fault), 0);
        rst = 0; enable = 0; is_turning = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
